// File: rtl/conv_layer_ctrl.sv
// conv_layer_ctrl: sequences one CONV layer. It kicks the engine, feeds the
// IFM and weight requests from two 1-cycle-latency SRAMs through wrapping
// address counters, stores every result in the OFM SRAM and reports either
// done or a latched error code to the host.
module conv_layer_ctrl #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int IFM_WIDTH    = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int IFM_BASE     = 0,
  parameter int WGT_BASE     = 0,
  parameter int OFM_BASE     = 0,
  parameter int IFM_WORDS    = 12288,
  parameter int WGT_WORDS    = 216,
  parameter int OFM_WORDS    = 30752,
  parameter int TIMEOUT      = 65535
) (
  input  logic                    clk1,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [1:0]              err_code,
  output logic                    start_conv,
  input  logic                    ifm_read,
  input  logic                    wgt_read,
  input  logic                    out_valid,
  input  logic                    end_conv,
  input  logic [DATA_WIDTH-1:0]   data_output,
  output logic [IFM_WIDTH-1:0]    ifm,
  output logic [WEIGHT_WIDTH-1:0] wgt,
  output logic                    ifm_en,
  output logic [ADDR_WIDTH-1:0]   ifm_addr,
  input  logic [IFM_WIDTH-1:0]    ifm_rdata,
  output logic                    wgt_en,
  output logic [ADDR_WIDTH-1:0]   wgt_addr,
  input  logic [WEIGHT_WIDTH-1:0] wgt_rdata,
  output logic                    ofm_we,
  output logic [ADDR_WIDTH-1:0]   ofm_addr,
  output logic [DATA_WIDTH-1:0]   ofm_wdata
);

  // The OFM counter needs one extra bit so it can sit at OFM_WORDS itself.
  localparam int CW = ADDR_WIDTH + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [ADDR_WIDTH-1:0] IFM_BASE_C  = ADDR_WIDTH'(IFM_BASE);
  localparam logic [ADDR_WIDTH-1:0] WGT_BASE_C  = ADDR_WIDTH'(WGT_BASE);
  localparam logic [ADDR_WIDTH-1:0] OFM_BASE_C  = ADDR_WIDTH'(OFM_BASE);
  localparam logic [ADDR_WIDTH-1:0] IFM_LAST_C  = ADDR_WIDTH'(IFM_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] WGT_LAST_C  = ADDR_WIDTH'(WGT_WORDS - 1);
  localparam logic [CW-1:0]         OFM_WORDS_C = CW'(OFM_WORDS);
  localparam logic [TW-1:0]         TO_LAST_C   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_KICK, S_RUN, S_DRAIN} state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   ifm_cnt_reg;
  logic [ADDR_WIDTH-1:0]   wgt_cnt_reg;
  logic [CW-1:0]           ofm_cnt_reg;
  logic [TW-1:0]           to_cnt_reg;
  logic                    ifm_vld_reg;
  logic                    wgt_vld_reg;
  logic                    err_reg;
  logic [1:0]              err_code_reg;
  logic                    done_ok_reg;

  logic                    accept;
  logic                    ifm_fire;
  logic                    wgt_fire;
  logic                    ofm_fire;
  logic                    ofm_ovf;
  logic                    end_hit;
  logic                    to_hit;
  logic                    clean_end;
  logic [CW-1:0]           ofm_cnt_after;

  // Request qualification: which engine strobes are honoured in each state.
  always_comb begin
    accept        = (state_reg == S_IDLE) && start;
    ifm_fire      = ((state_reg == S_KICK) || (state_reg == S_RUN)) && ifm_read;
    wgt_fire      = (state_reg == S_KICK) || ((state_reg == S_RUN) && wgt_read);
    ofm_fire      = ((state_reg == S_RUN) || (state_reg == S_DRAIN)) && out_valid
                    && (ofm_cnt_reg < OFM_WORDS_C);
    ofm_ovf       = ((state_reg == S_RUN) || (state_reg == S_DRAIN)) && out_valid
                    && (ofm_cnt_reg >= OFM_WORDS_C);
    end_hit       = (state_reg == S_RUN) && end_conv;
    to_hit        = (state_reg == S_RUN) && !out_valid && !end_conv
                    && (to_cnt_reg == TO_LAST_C);
    ofm_cnt_after = ofm_cnt_reg + CW'(ofm_fire);
    clean_end     = end_hit && (ofm_cnt_after == OFM_WORDS_C) && !err_reg && !ofm_ovf;
  end

  // State register.
  always_ff @(posedge clk1) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state decode and all combinational outputs; SRAM ports read as 0 when idle.
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    start_conv = 1'b0;
    done       = 1'b0;
    ifm_en     = 1'b0;
    ifm_addr   = '0;
    wgt_en     = 1'b0;
    wgt_addr   = '0;
    ofm_we     = 1'b0;
    ofm_addr   = '0;
    ofm_wdata  = '0;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_KICK;
      S_KICK: begin
        busy       = 1'b1;
        start_conv = 1'b1;
        state_next = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (end_conv || to_hit) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        busy       = 1'b1;
        done       = done_ok_reg;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (ifm_fire) begin
      ifm_en   = 1'b1;
      ifm_addr = IFM_BASE_C + ifm_cnt_reg;
    end
    if (wgt_fire) begin
      wgt_en   = 1'b1;
      wgt_addr = WGT_BASE_C + wgt_cnt_reg;
    end
    if (ofm_fire) begin
      ofm_we    = 1'b1;
      ofm_addr  = OFM_BASE_C + ofm_cnt_reg[ADDR_WIDTH-1:0];
      ofm_wdata = data_output;
    end
  end

  // Address/timeout counters, cleared when a layer is accepted so KICK starts at the bases.
  always_ff @(posedge clk1) begin
    if (rst) begin
      ifm_cnt_reg <= '0;
      wgt_cnt_reg <= '0;
      ofm_cnt_reg <= '0;
      to_cnt_reg  <= '0;
      ifm_vld_reg <= 1'b0;
      wgt_vld_reg <= 1'b0;
    end else begin
      ifm_vld_reg <= ifm_fire;
      wgt_vld_reg <= wgt_fire;
      if (accept) begin
        ifm_cnt_reg <= '0;
        wgt_cnt_reg <= '0;
        ofm_cnt_reg <= '0;
        to_cnt_reg  <= '0;
      end else begin
        if (ifm_fire)
          ifm_cnt_reg <= (ifm_cnt_reg == IFM_LAST_C) ? '0 : ifm_cnt_reg + 1'b1;
        if (wgt_fire)
          wgt_cnt_reg <= (wgt_cnt_reg == WGT_LAST_C) ? '0 : wgt_cnt_reg + 1'b1;
        if (ofm_fire)
          ofm_cnt_reg <= ofm_cnt_reg + CW'(1);
        if (state_reg == S_RUN)
          to_cnt_reg <= out_valid ? '0 : to_cnt_reg + TW'(1);
      end
    end
  end

  // Sticky error with first-error-wins code, and the clean-finish flag shown as done in DRAIN.
  always_ff @(posedge clk1) begin
    if (rst) begin
      err_reg      <= 1'b0;
      err_code_reg <= 2'b00;
      done_ok_reg  <= 1'b0;
    end else if (accept) begin
      err_reg      <= 1'b0;
      err_code_reg <= 2'b00;
      done_ok_reg  <= 1'b0;
    end else begin
      done_ok_reg <= clean_end;
      if (!err_reg) begin
        if (ofm_ovf) begin
          err_reg      <= 1'b1;
          err_code_reg <= 2'b01;
        end else if (end_hit && !clean_end) begin
          err_reg      <= 1'b1;
          err_code_reg <= 2'b10;
        end else if (to_hit) begin
          err_reg      <= 1'b1;
          err_code_reg <= 2'b11;
        end
      end
    end
  end

  assign err      = err_reg;
  assign err_code = err_code_reg;
  assign ifm      = ifm_vld_reg ? ifm_rdata : '0;
  assign wgt      = wgt_vld_reg ? wgt_rdata : '0;

endmodule

// File: tb/tb_conv_layer_ctrl.sv
// tb_conv_layer_ctrl: directed bench with a per-cycle vector table for a full
// nominal layer (including IFM/weight wrap) plus hand-written sequences for
// overflow, short layer, timeout, reset abort and ignored restart.
module tb_conv_layer_ctrl;

  logic        clk1 = 1'b0;
  logic        rst, start, ifm_read, wgt_read, out_valid, end_conv;
  logic [15:0] data_output;
  logic        busy, done, err, start_conv, ifm_en, wgt_en, ofm_we;
  logic [1:0]  err_code;
  logic [7:0]  ifm, wgt, ifm_rdata, wgt_rdata;
  logic [15:0] ifm_addr, wgt_addr, ofm_addr, ofm_wdata;

  logic [7:0]  ifm_mem [16];
  logic [7:0]  wgt_mem [4];
  logic [15:0] ofm_mem [8];
  int          wr_count   = 0;
  int          done_count = 0;
  int          total = 0;
  int          bad   = 0;

  conv_layer_ctrl #(
    .IFM_WORDS(16), .WGT_WORDS(4), .OFM_WORDS(8), .TIMEOUT(10)
  ) dut (
    .clk1(clk1), .rst(rst), .start(start), .busy(busy), .done(done),
    .err(err), .err_code(err_code), .start_conv(start_conv),
    .ifm_read(ifm_read), .wgt_read(wgt_read), .out_valid(out_valid),
    .end_conv(end_conv), .data_output(data_output), .ifm(ifm), .wgt(wgt),
    .ifm_en(ifm_en), .ifm_addr(ifm_addr), .ifm_rdata(ifm_rdata),
    .wgt_en(wgt_en), .wgt_addr(wgt_addr), .wgt_rdata(wgt_rdata),
    .ofm_we(ofm_we), .ofm_addr(ofm_addr), .ofm_wdata(ofm_wdata)
  );

  always #5 clk1 = ~clk1;

  // SRAM models: registered reads, OFM write capture with a log line per write.
  always @(posedge clk1) begin
    if (ifm_en) ifm_rdata <= ifm_mem[ifm_addr[3:0]];
    if (wgt_en) wgt_rdata <= wgt_mem[wgt_addr[1:0]];
    if (ofm_we) begin
      ofm_mem[ofm_addr[2:0]] <= ofm_wdata;
      wr_count <= wr_count + 1;
      $display("ofm write addr=%0d data=%h", ofm_addr, ofm_wdata);
    end
    if (done) done_count <= done_count + 1;
  end

  typedef struct {
    logic        ird, wrd, ov, ec;
    logic [15:0] dout;
    logic        ien;
    logic [15:0] iaddr;
    logic [7:0]  ifmv;
    logic        wen;
    logic [15:0] waddr;
    logic [7:0]  wgtv;
    logic        we;
    logic [15:0] oaddr, odata;
    logic        bsy, dn;
  } vec_t;

  vec_t tbl [22];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    start = 0; ifm_read = 0; wgt_read = 0; out_valid = 0; end_conv = 0; data_output = '0;
  endtask

  // Pulse start in IDLE; returns positioned in the KICK cycle (negedge + 2).
  task automatic kick();
    @(negedge clk1); start = 1;
    @(negedge clk1); start = 0; #2;
  endtask

  initial begin
    int wr_base, done_base;
    for (int i = 0; i < 16; i++) ifm_mem[i] = 8'hA0 + 8'(i);
    for (int i = 0; i < 4; i++)  wgt_mem[i] = 8'h50 + 8'(i);

    // Nominal layer: 20 ifm reads (wraps after 16), 4 weight reads plus the
    // KICK prefetch, 8 outputs with the last one in the end_conv cycle.
    for (int r = 0; r < 22; r++) begin
      tbl[r] = '{default: '0};
      if (r < 20) begin
        tbl[r].ird = 1; tbl[r].ien = 1; tbl[r].iaddr = 16'(r % 16);
      end
      if (r == 20) tbl[r].ird = 1;
      if (r >= 1 && r <= 20) tbl[r].ifmv = 8'hA0 + 8'((r - 1) % 16);
      if (r < 4) begin
        tbl[r].wrd = 1; tbl[r].wen = 1; tbl[r].waddr = 16'((r + 1) % 4);
      end
      if (r == 20) tbl[r].wrd = 1;
      if (r == 0) tbl[r].wgtv = 8'h50;
      if (r >= 1 && r <= 4) tbl[r].wgtv = 8'h50 + 8'(r % 4);
      if ((r >= 5 && r <= 11) || r == 19) begin
        tbl[r].ov = 1; tbl[r].dout = 16'h1000 + 16'(r);
        tbl[r].we = 1; tbl[r].oaddr = (r == 19) ? 16'd7 : 16'(r - 5);
        tbl[r].odata = tbl[r].dout;
      end
      tbl[r].ec  = (r == 19);
      tbl[r].bsy = (r <= 20);
      tbl[r].dn  = (r == 20);
    end

    rst = 1; idle_inputs();
    repeat (3) @(negedge clk1);
    #2;
    chk("reset_outputs", {busy, done, err, err_code, start_conv, ifm, wgt, ifm_en, ifm_addr,
                          wgt_en, wgt_addr, ofm_we, ofm_addr, ofm_wdata}, '0);
    @(negedge clk1); rst = 0;

    // ---- nominal ----
    wr_base = wr_count; done_base = done_count;
    @(negedge clk1); start = 1; #2;
    chk("idle_no_start_conv", {busy, start_conv}, 2'b00);
    @(negedge clk1); start = 0; #2;
    chk("kick", {start_conv, busy, wgt_en, wgt_addr, ifm_en, err}, {1'b1, 1'b1, 1'b1, 16'd0, 1'b0, 1'b0});
    for (int r = 0; r < 22; r++) begin
      @(negedge clk1);
      ifm_read = tbl[r].ird; wgt_read = tbl[r].wrd; out_valid = tbl[r].ov;
      end_conv = tbl[r].ec;  data_output = tbl[r].dout;
      #2;
      $display("row %0d ifm_en=%b ifm_addr=%0d ifm=%h wgt_en=%b wgt_addr=%0d wgt=%h we=%b oaddr=%0d busy=%b done=%b",
               r, ifm_en, ifm_addr, ifm, wgt_en, wgt_addr, wgt, ofm_we, ofm_addr, busy, done);
      chk($sformatf("nominal_row%0d", r),
          {ifm_en, ifm_addr, ifm, wgt_en, wgt_addr, wgt, ofm_we, ofm_addr, ofm_wdata, busy, done, err},
          {tbl[r].ien, tbl[r].iaddr, tbl[r].ifmv, tbl[r].wen, tbl[r].waddr, tbl[r].wgtv,
           tbl[r].we, tbl[r].oaddr, tbl[r].odata, tbl[r].bsy, tbl[r].dn, 1'b0});
    end
    idle_inputs();
    for (int i = 0; i < 8; i++)
      chk($sformatf("ofm_mem%0d", i), ofm_mem[i], (i < 7) ? 16'h1005 + 16'(i) : 16'h1013);
    chk("nominal_writes", wr_count - wr_base, 8);
    chk("nominal_done_once", done_count - done_base, 1);

    // ---- overflow: 9 outputs into an 8-word OFM ----
    wr_base = wr_count; done_base = done_count;
    kick();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk1); out_valid = 1; data_output = 16'h2000 + 16'(i); #2;
      $display("ovf out %0d we=%b addr=%0d err=%b", i, ofm_we, ofm_addr, err);
      if (i == 7) chk("ovf_8th_written", {ofm_we, ofm_addr}, {1'b1, 16'd7});
      if (i == 8) chk("ovf_9th_blocked", {ofm_we, err}, 2'b00);
    end
    @(negedge clk1); out_valid = 0; end_conv = 1; #2;
    chk("ovf_err", {err, err_code}, 3'b101);
    @(negedge clk1); end_conv = 0; #2;
    chk("ovf_drain", {busy, done, err, err_code}, 5'b10101);
    @(negedge clk1); #2;
    chk("ovf_idle", {busy, err, err_code}, 4'b0101);
    chk("ovf_writes", wr_count - wr_base, 8);
    chk("ovf_no_done", done_count - done_base, 0);
    chk("ovf_mem7", ofm_mem[7], 16'h2007);

    // ---- short layer: end_conv after 5 outputs ----
    kick();
    chk("short_kick_clears_err", {err, err_code}, 3'b000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk1); out_valid = 1; data_output = 16'h3000 + 16'(i);
    end
    @(negedge clk1); out_valid = 0; end_conv = 1;
    @(negedge clk1); end_conv = 0; #2;
    chk("short_drain", {busy, done, err, err_code}, 5'b10110);
    @(negedge clk1); #2;
    chk("short_idle", {busy, err, err_code}, 4'b0110);

    // ---- timeout: 10 quiet RUN cycles ----
    kick();
    chk("to_kick_clears_err", {err, err_code}, 3'b000);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk1); #2;
      if (i == 10) chk("to_not_early", {busy, err}, 2'b10);
    end
    @(negedge clk1); #2;
    chk("to_drain", {busy, done, err, err_code}, 5'b10111);
    @(negedge clk1); #2;
    chk("to_busy_fall", {busy, err, err_code}, 4'b0111);

    // ---- reset mid-RUN, restart, ignored start in DRAIN ----
    kick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk1); ifm_read = 1; wgt_read = 1;
    end
    @(negedge clk1); rst = 1; out_valid = 1; data_output = 16'hBEEF;
    @(negedge clk1); #2;
    chk("rst_mid_run", {busy, done, err, err_code, start_conv, ifm, wgt, ifm_en, ifm_addr,
                        wgt_en, wgt_addr, ofm_we, ofm_addr, ofm_wdata}, '0);
    @(negedge clk1); rst = 0; idle_inputs();
    @(negedge clk1); start = 1;
    @(negedge clk1); start = 0; ifm_read = 1; #2;
    chk("restart_kick", {start_conv, wgt_en, wgt_addr, ifm_en, ifm_addr},
        {1'b1, 1'b1, 16'd0, 1'b1, 16'd0});
    @(negedge clk1); ifm_read = 0; end_conv = 1; #2;
    chk("restart_data", {ifm, wgt}, {8'hA0, 8'h50});
    @(negedge clk1); end_conv = 0; start = 1; #2;
    chk("restart_drain", {busy, done, err, err_code}, 5'b10110);
    @(negedge clk1); start = 0; #2;
    chk("drain_start_ignored", {busy, start_conv}, 2'b00);
    @(negedge clk1); start = 1;
    @(negedge clk1); start = 0; #2;
    chk("idle_start_accepted", {busy, start_conv, err}, 3'b110);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/conv_layer_ctrl.md
# conv_layer_ctrl

Single-layer sequencer for the `CONV` engine. It accepts a host `start`, pulses `start_conv`, and services the engine's `ifm_read`/`wgt_read` requests from two 1-cycle-latency read SRAMs using wrapping address counters. It writes every `out_valid` result into an OFM SRAM and reports completion or error to the host. It sits between the layer scheduler (host side) and `CONV` plus its three buffers, and replaces the bench-side feeders.

## Interface
Parameters:
- `ADDR_WIDTH`, 16: width of all SRAM addresses.
- `DATA_WIDTH`, 16: OFM word width (`data_output`).
- `IFM_WIDTH`, 8: IFM word width.
- `WEIGHT_WIDTH`, 8: weight word width.
- `IFM_BASE`, 0: first IFM address.
- `WGT_BASE`, 0: first weight address.
- `OFM_BASE`, 0: first OFM address.
- `IFM_WORDS`, 12288: CI*IFM_SIZE*IFM_SIZE (3*64*64).
- `WGT_WORDS`, 216: CO*CI*K*K (8*3*3*3).
- `OFM_WORDS`, 30752: expected outputs (62*62*8).
- `TIMEOUT`, 65535: max RUN cycles with no `out_valid`.

Ports:
- `clk1` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: host layer start, 1-cycle pulse.
- `busy` out 1: high from KICK through DRAIN.
- `done` out 1: 1-cycle pulse, layer completed cleanly.
- `err` out 1: sticky; cleared by the next accepted `start` or by `rst`.
- `err_code` out 2: 01 output overflow, 10 count mismatch at `end_conv`, 11 timeout.
- `start_conv` out 1: to `CONV`, 1-cycle pulse.
- `ifm_read` in 1: from `CONV`.
- `wgt_read` in 1: from `CONV`.
- `out_valid` in 1: from `CONV`.
- `end_conv` in 1: from `CONV`.
- `data_output` in DATA_WIDTH: from `CONV`.
- `ifm` out IFM_WIDTH: to `CONV`.
- `wgt` out WEIGHT_WIDTH: to `CONV`.
- `ifm_en` out 1: IFM SRAM read enable.
- `ifm_addr` out ADDR_WIDTH: IFM SRAM address.
- `ifm_rdata` in IFM_WIDTH: IFM SRAM data, valid one cycle after `ifm_en`.
- `wgt_en` out 1: weight SRAM read enable.
- `wgt_addr` out ADDR_WIDTH: weight SRAM address.
- `wgt_rdata` in WEIGHT_WIDTH: weight SRAM data, valid one cycle after `wgt_en`.
- `ofm_we` out 1: OFM SRAM write enable.
- `ofm_addr` out ADDR_WIDTH: OFM SRAM address.
- `ofm_wdata` out DATA_WIDTH: OFM SRAM write data.

## Operation
- FSM states: IDLE, KICK, RUN, DRAIN.
  - IDLE→KICK on `start`.
  - KICK→RUN unconditionally after 1 cycle.
  - RUN→DRAIN on `end_conv`, or on timeout.
  - DRAIN→IDLE after 1 cycle.
  - `start` outside IDLE is ignored.
- KICK:
  - `start_conv`=1.
  - Clears `ifm_cnt`, `wgt_cnt`, `ofm_cnt`, the timeout counter and `err`.
  - `wgt_en`=1 at address `WGT_BASE`. This is the weight prefetch; `wgt_cnt` becomes 1.
- IFM path (KICK, RUN):
  - `ifm_en` = `ifm_read`, combinational; `ifm_addr` = `IFM_BASE + ifm_cnt`.
  - `ifm_cnt` increments on each read and wraps to 0 after `IFM_WORDS-1`.
  - `ifm` = `ifm_rdata` in the cycle after a read, else 0.
- Weight path (RUN):
  - `wgt_en` = `wgt_read`; `wgt_addr` = `WGT_BASE + wgt_cnt`.
  - `wgt_cnt` wraps to 0 after `WGT_WORDS-1`.
  - `wgt` = `wgt_rdata` in the cycle after `wgt_en`, else 0.
- OFM path (RUN, DRAIN):
  - When `out_valid` and `ofm_cnt < OFM_WORDS`: `ofm_we`=1, `ofm_addr` = `OFM_BASE + ofm_cnt`, `ofm_wdata` = `data_output`, all combinational from the current cycle; then `ofm_cnt`++.
  - When `out_valid` and `ofm_cnt == OFM_WORDS`: no write; `err`=1, `err_code`=01.
- End of layer:
  - `end_conv` with `ofm_cnt` (including a same-cycle write) == `OFM_WORDS` and no error: `done` pulses in the DRAIN cycle.
  - Otherwise: `err`=1, `err_code`=10 unless an error is already latched.
- Timeout:
  - The counter resets on every `out_valid`; it counts RUN cycles.
  - Reaching `TIMEOUT` sets `err`=1, `err_code`=11 and enters DRAIN.
- The first error latched wins; `err_code` does not change until cleared.
- `ifm_read`/`wgt_read` arriving in IDLE or DRAIN are ignored: no enable, and the counters hold.

## Timing
- Reset values: all outputs 0, state IDLE, all counters 0.
- `rst` asserted mid-layer aborts on the next edge: no `done`, `err`=0.
- Latencies:
  - `start`→`start_conv`: 1 cycle.
  - `ifm_read`/`wgt_read`→data on `ifm`/`wgt`: 1 cycle.
  - `out_valid`→SRAM write: 0 cycles.
  - `end_conv`→`done`: 1 cycle.
- One IFM read, one weight read and one OFM write per cycle are all allowed, because the three SRAMs are independent.
- Back-to-back `start`: the pulse landing on the DRAIN→IDLE cycle is ignored; one arriving in IDLE is accepted.

## Test plan
- Nominal, with IFM_WORDS=16, WGT_WORDS=4, OFM_WORDS=8 and a model CONV issuing 16 ifm reads, 4 weight reads and 8 `out_valid`:
  - OFM addresses 0..7 are written with the matching data.
  - `done` pulses once, 1 cycle after `end_conv`; `err`=0.
- Wrap: issue 20 ifm reads. The addresses go 0..15 then 0..3, and `ifm` shows the matching SRAM words 1 cycle later.
- Overflow: issue 9 `out_valid` with OFM_WORDS=8. The 9th is not written; `err`=1, `err_code`=01, and `done` never pulses.
- Short layer: `end_conv` after 5 outputs → `err_code`=10, DRAIN, then IDLE.
- Timeout, with TIMEOUT=10: no `out_valid` for 10 RUN cycles → `err_code`=11, `busy` falls 2 cycles later.
- Reset and restart:
  - `rst` asserted mid-RUN → all outputs 0.
  - A new `start` then reads from `IFM_BASE`/`WGT_BASE` again, with the weight prefetch in KICK.
  - A second `start` in the DRAIN cycle is ignored.
